// File: rtl/comb_func_unit_if.sv
// Signal bundle for comb_func_unit: the input vector and its qualifier, plus the
// combinational, registered and cross-check results.
interface comb_func_unit_if #(
    parameter int CNT_W = 5
);
    logic             a;
    logic             b;
    logic             c;
    logic             d;
    logic             in_valid;
    logic             y;
    logic             y_q;
    logic             out_valid;
    logic             mismatch;
    logic             err_sticky;
    logic [CNT_W-1:0] vec_cnt;

    modport master (
        output a, b, c, d, in_valid,
        input  y, y_q, out_valid, mismatch, err_sticky, vec_cnt
    );

    modport slave (
        input  a, b, c, d, in_valid,
        output y, y_q, out_valid, mismatch, err_sticky, vec_cnt
    );
endinterface

// File: rtl/comb_func_unit.sv
// Reference cell for y = ~(a & b & c & ~d), with a 1-cycle registered copy and a vector counter.
// Define COMB_XCHECK_EN to build gate, dataflow and behavioural copies and flag any disagreement.
module comb_func_unit #(
    parameter logic RESET_Y = 1'b1,
    parameter int   CNT_W   = 5
) (
    input logic            clk,
    input logic            rst,
    comb_func_unit_if.slave bus
);

    logic             y_df;
    logic             disagree;
    logic             y_q_r;
    logic             out_valid_r;
    logic             mismatch_r;
    logic             err_sticky_r;
    logic [CNT_W-1:0] vec_cnt_r;

    // Written in the original two-term form so the factoring stays visible.
    assign y_df = ~((bus.a | bus.d) & (bus.b & bus.c & ~bus.d));

`ifdef COMB_XCHECK_EN
    logic d_n;
    logic a_or_d;
    logic bc_nd;
    logic y_gate;
    logic y_beh;

    not  u_not_d  (d_n, bus.d);
    or   u_or_ad  (a_or_d, bus.a, bus.d);
    and  u_and_bc (bc_nd, bus.b, bus.c, d_n);
    nand u_nand_y (y_gate, a_or_d, bc_nd);

    always_comb begin
        y_beh = 1'b1;
        case ({bus.a, bus.b, bus.c, bus.d})
            4'b1110: y_beh = 1'b0;
            default: y_beh = 1'b1;
        endcase
    end

    assign disagree = ~((y_gate == y_df) && (y_df == y_beh));
`else
    assign disagree = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q_r        <= RESET_Y;
            out_valid_r  <= 1'b0;
            mismatch_r   <= 1'b0;
            err_sticky_r <= 1'b0;
            vec_cnt_r    <= '0;
        end else if (bus.in_valid) begin
            y_q_r        <= y_df;
            out_valid_r  <= 1'b1;
            mismatch_r   <= disagree;
            err_sticky_r <= err_sticky_r | disagree;
            vec_cnt_r    <= vec_cnt_r + 1'b1;
        end else begin
            out_valid_r  <= 1'b0;
            mismatch_r   <= 1'b0;
        end
    end

    assign bus.y          = y_df;
    assign bus.y_q        = y_q_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.mismatch   = mismatch_r;
    assign bus.err_sticky = err_sticky_r;
    assign bus.vec_cnt    = vec_cnt_r;

endmodule

// File: tb/tb_comb_func_unit.sv
// Scoreboard bench for comb_func_unit: the driver queues expected registered results,
// a negedge monitor pops and compares them whenever out_valid is high.
module tb_comb_func_unit;

    localparam int CNT_W = 5;

    logic clk;
    logic rst;

    comb_func_unit_if #(.CNT_W(CNT_W)) bus ();

    comb_func_unit #(.RESET_Y(1'b1), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic             yq;
        logic [CNT_W-1:0] cnt;
        logic             mm;
        logic             err;
    } exp_t;

    exp_t sbq[$];

    int vectors     = 0;
    int miscompares = 0;

    // y is 0 only at index 14 (4'b1110)
    logic [15:0]      y_table = 16'hBFFF;
    logic [CNT_W-1:0] m_cnt   = '0;
    logic             m_yq    = 1'b1;
    logic             m_err   = 1'b0;
    logic             forced  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic valid, input logic fault);
        exp_t e;
        @(posedge clk);
        #1;
`ifdef COMB_XCHECK_EN
        if (forced) begin
            release dut.y_gate;
            forced = 1'b0;
        end
`endif
        {bus.a, bus.b, bus.c, bus.d} = v;
        bus.in_valid = valid;
`ifdef COMB_XCHECK_EN
        if (fault) begin
            force dut.y_gate = ~y_table[v];
            forced = 1'b1;
        end
`endif
        #1;
        chk($sformatf("y[%0d]", v), {31'b0, bus.y}, {31'b0, y_table[v]});
        if (valid && !rst) begin
            m_cnt  = m_cnt + 1'b1;
            m_yq   = y_table[v];
`ifdef COMB_XCHECK_EN
            e.mm   = fault;
`else
            e.mm   = 1'b0;
`endif
            m_err  = m_err | e.mm;
            e.yq   = m_yq;
            e.cnt  = m_cnt;
            e.err  = m_err;
            sbq.push_back(e);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, ".out_valid"},  {31'b0, bus.out_valid},  32'd0);
        chk({name, ".y_q"},        {31'b0, bus.y_q},        {31'b0, m_yq});
        chk({name, ".vec_cnt"},    {27'b0, bus.vec_cnt},    {27'b0, m_cnt});
        chk({name, ".mismatch"},   {31'b0, bus.mismatch},   32'd0);
        chk({name, ".err_sticky"}, {31'b0, bus.err_sticky}, {31'b0, m_err});
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("sb.y_q",        {31'b0, bus.y_q},        {31'b0, e.yq});
                chk("sb.vec_cnt",    {27'b0, bus.vec_cnt},    {27'b0, e.cnt});
                chk("sb.mismatch",   {31'b0, bus.mismatch},   {31'b0, e.mm});
                chk("sb.err_sticky", {31'b0, bus.err_sticky}, {31'b0, e.err});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        {bus.a, bus.b, bus.c, bus.d} = 4'b1110;
        bus.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.y_comb", {31'b0, bus.y}, 32'd0);
        chk_idle("rst");
        rst          = 1'b0;
        bus.in_valid = 1'b0;

        for (int v = 0; v < 16; v++) drive(v[3:0], 1'b1, 1'b0);

        drive(4'b1110, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk_idle("gap");
        chk("gap.cnt16", {27'b0, bus.vec_cnt}, 32'd16);

        for (int v = 0; v < 16; v++) drive((v % 2 == 0) ? 4'b1110 : v[3:0], 1'b1, 1'b0);
        drive(4'b0000, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("wrap.cnt0", {27'b0, bus.vec_cnt}, 32'd0);

        drive(4'b1110, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        {bus.a, bus.b, bus.c, bus.d} = 4'b0011;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_cnt = '0;
        m_yq  = 1'b1;
        m_err = 1'b0;
        chk_idle("midrst");
        rst          = 1'b0;
        bus.in_valid = 1'b0;

        drive(4'b1110, 1'b1, 1'b0);
        drive(4'b0110, 1'b1, 1'b0);
`ifdef COMB_XCHECK_EN
        drive(4'b1110, 1'b1, 1'b1);
        drive(4'b1111, 1'b1, 1'b0);
        drive(4'b1010, 1'b1, 1'b0);
`endif
        drive(4'b1110, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk_idle("end");
        repeat (2) @(negedge clk);
        chk("sb.drained", sbq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
